blink_sched: RTL and testbench

Scheduler that shares the single `blink` engine among several requesters (fail indication, reprogram confirmation, future lockout warning) in the digital-lock design. Each requester posts a blink pattern (on time, off time, repeat count, target LED). The scheduler queues one pending pattern per requester and arbitrates between them. It sequences the engine through reset, run and completion, routes the engine's LED output to the selected board LED, and reports completion per requester. It sits between the top-level lock FSM and `blink`, replacing the direct `BLINK_GO`/`ON`/`OFF`/`REPEAT` drive.

---
 rtl/lock_pkg.sv | 36 +++
 rtl/blink_arb.sv | 56 +++++
 rtl/blink_sched.sv | 185 ++++++++++++++++++
 tb/tb_blink_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// ============================================================================
// lock_pkg : shared widths, LED-select codes and blink scheduler FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

    localparam int T_W_DEF = 5;
    localparam int R_W_DEF = 3;

    localparam logic [1:0] LSEL_NONE = 2'd0;
    localparam logic [1:0] LSEL_1    = 2'd1;
    localparam logic [1:0] LSEL_2    = 2'd2;
    localparam logic [1:0] LSEL_3    = 2'd3;

    typedef enum logic [1:0] {
        BS_IDLE   = 2'd0,
        BS_LOAD   = 2'd1,
        BS_RUN    = 2'd2,
        BS_FINISH = 2'd3
    } bs_state_e;

    function automatic logic [2:0] sel_to_ovr(input logic [1:0] sel);
        case (sel)
            LSEL_NONE: return 3'b000;
            LSEL_1:    return 3'b001;
            LSEL_2:    return 3'b010;
            LSEL_3:    return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/blink_arb.sv
// ============================================================================
// blink_arb : one-hot grant over the pending vector; round-robin pointer is
// built only when BLINK_SCHED_RR_EN is defined, else fixed lowest-index wins.
// Rev 1.0
// ============================================================================
`default_nettype none

module blink_arb #(
    parameter int N_REQ = 3
) (
`ifdef BLINK_SCHED_RR_EN
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_i,
`endif
    input  logic [N_REQ-1:0] pend_i,
    output logic [N_REQ-1:0] gnt_o
);

`ifdef BLINK_SCHED_RR_EN
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Pointer holds the index after the last granted requester.
    logic [PW-1:0] ptr_q;

    always_comb begin
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && pend_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (upd_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt_o[k]) ptr_q <= (k == N_REQ - 1) ? '0 : PW'(k + 1);
            end
        end
    end
`else
    assign gnt_o = pend_i & (~pend_i + 1'b1);
`endif

endmodule

`default_nettype wire

// File: rtl/blink_sched.sv
// ============================================================================
// blink_sched : shares one blink engine among N_REQ requesters, one pending
// pattern each. Option macro: BLINK_SCHED_RR_EN (round-robin arbitration).
// Rev 1.0
// ============================================================================
`default_nettype none

module blink_sched
    import lock_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int T_W   = T_W_DEF,
    parameter int R_W   = R_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [N_REQ*T_W-1:0] PAT_ON,
    input  logic [N_REQ*T_W-1:0] PAT_OFF,
    input  logic [N_REQ*R_W-1:0] PAT_REP,
    input  logic [N_REQ*2-1:0] PAT_SEL,
    input  logic               CANCEL,
    output logic [N_REQ-1:0]   DONE,
    output logic [N_REQ-1:0]   ACTIVE,
    output logic               BUSY,
    output logic               B_RST,
    output logic               B_GO,
    output logic [T_W-1:0]     B_ON,
    output logic [T_W-1:0]     B_OFF,
    output logic [R_W-1:0]     B_REP,
    input  logic               B_DONE,
    input  logic               B_LED,
    output logic [2:0]         LED_OVR,
    output logic [2:0]         LED_VAL
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    bs_state_e        state_q;
    logic [N_REQ-1:0] pending_q;
    logic [T_W-1:0]   on_q  [N_REQ];
    logic [T_W-1:0]   off_q [N_REQ];
    logic [R_W-1:0]   rep_q [N_REQ];
    logic [1:0]       sel_q [N_REQ];

    logic [N_REQ-1:0] done_q;
    logic [N_REQ-1:0] active_q;
    logic             busy_q;
    logic             b_rst_q;
    logic             b_go_q;
    logic [T_W-1:0]   b_on_q;
    logic [T_W-1:0]   b_off_q;
    logic [R_W-1:0]   b_rep_q;
    logic [2:0]       led_ovr_q;

    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_clr;
    logic [IW-1:0]    w_gidx;
    logic             w_grant;

    assign w_grant = (state_q == BS_IDLE) && (|pending_q) && !CANCEL;
    assign w_clr   = w_gnt & {N_REQ{w_grant}};

    blink_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
`ifdef BLINK_SCHED_RR_EN
        .clk    (CLK),
        .rst    (RST),
        .upd_i  (w_grant),
`endif
        .pend_i (pending_q),
        .gnt_o  (w_gnt)
    );

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_gidx = IW'(i);
        end
    end

    // A REQ landing in the grant cycle re-pends rather than being lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                on_q[i]  <= '0;
                off_q[i] <= '0;
                rep_q[i] <= '0;
                sel_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (REQ[i]) begin
                    on_q[i]  <= PAT_ON[i*T_W +: T_W];
                    off_q[i] <= PAT_OFF[i*T_W +: T_W];
                    rep_q[i] <= PAT_REP[i*R_W +: R_W];
                    sel_q[i] <= PAT_SEL[i*2 +: 2];
                end
            end
            if (CANCEL) pending_q <= '0;
            else        pending_q <= (pending_q & ~w_clr) | REQ;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= BS_IDLE;
            done_q    <= '0;
            active_q  <= '0;
            busy_q    <= 1'b0;
            b_rst_q   <= 1'b0;
            b_go_q    <= 1'b0;
            b_on_q    <= '0;
            b_off_q   <= '0;
            b_rep_q   <= '0;
            led_ovr_q <= '0;
        end else begin
            done_q <= '0;
            if (CANCEL) begin
                state_q   <= BS_IDLE;
                active_q  <= '0;
                busy_q    <= 1'b0;
                b_rst_q   <= 1'b0;
                b_go_q    <= 1'b0;
                led_ovr_q <= '0;
            end else begin
                case (state_q)
                    BS_IDLE: begin
                        if (|pending_q) begin
                            state_q   <= BS_LOAD;
                            active_q  <= w_gnt;
                            busy_q    <= 1'b1;
                            b_rst_q   <= 1'b1;
                            b_on_q    <= on_q[w_gidx];
                            b_off_q   <= off_q[w_gidx];
                            b_rep_q   <= rep_q[w_gidx];
                            led_ovr_q <= sel_to_ovr(sel_q[w_gidx]);
                        end
                    end
                    BS_LOAD: begin
                        b_rst_q <= 1'b0;
                        if (b_rep_q == '0) begin
                            state_q   <= BS_FINISH;
                            done_q    <= active_q;
                            led_ovr_q <= '0;
                        end else begin
                            state_q <= BS_RUN;
                            b_go_q  <= 1'b1;
                        end
                    end
                    BS_RUN: begin
                        if (B_DONE) begin
                            state_q   <= BS_FINISH;
                            done_q    <= active_q;
                            b_go_q    <= 1'b0;
                            led_ovr_q <= '0;
                        end
                    end
                    BS_FINISH: begin
                        state_q  <= BS_IDLE;
                        active_q <= '0;
                        busy_q   <= 1'b0;
                    end
                    default: state_q <= BS_IDLE;
                endcase
            end
        end
    end

    assign DONE    = done_q;
    assign ACTIVE  = active_q;
    assign BUSY    = busy_q;
    assign B_RST   = b_rst_q;
    assign B_GO    = b_go_q;
    assign B_ON    = b_on_q;
    assign B_OFF   = b_off_q;
    assign B_REP   = b_rep_q;
    assign LED_OVR = led_ovr_q;
    assign LED_VAL = led_ovr_q & {3{B_LED}};

endmodule

`default_nettype wire

// File: tb/tb_blink_sched.sv
// ============================================================================
// tb_blink_sched : directed self-checking bench for blink_sched with a stub
// blink engine that raises B_DONE a programmable number of cycles after B_GO.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_blink_sched;

    localparam int N_REQ = 3;
    localparam int T_W   = 5;
    localparam int R_W   = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*T_W-1:0]   pat_on = '0;
    logic [N_REQ*T_W-1:0]   pat_off = '0;
    logic [N_REQ*R_W-1:0]   pat_rep = '0;
    logic [N_REQ*2-1:0]     pat_sel = '0;
    logic                   cancel = 1'b0;
    logic [N_REQ-1:0]       done;
    logic [N_REQ-1:0]       active;
    logic                   busy;
    logic                   b_rst;
    logic                   b_go;
    logic [T_W-1:0]         b_on;
    logic [T_W-1:0]         b_off;
    logic [R_W-1:0]         b_rep;
    logic                   b_done;
    logic                   b_led;
    logic [2:0]             led_ovr;
    logic [2:0]             led_val;

    int n_tests = 0;
    int n_fail  = 0;
    int dly     = 20;
    int cnt;

    always #5 clk = ~clk;

    blink_sched #(
        .N_REQ (N_REQ),
        .T_W   (T_W),
        .R_W   (R_W)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .PAT_ON  (pat_on),
        .PAT_OFF (pat_off),
        .PAT_REP (pat_rep),
        .PAT_SEL (pat_sel),
        .CANCEL  (cancel),
        .DONE    (done),
        .ACTIVE  (active),
        .BUSY    (busy),
        .B_RST   (b_rst),
        .B_GO    (b_go),
        .B_ON    (b_on),
        .B_OFF   (b_off),
        .B_REP   (b_rep),
        .B_DONE  (b_done),
        .B_LED   (b_led),
        .LED_OVR (led_ovr),
        .LED_VAL (led_val)
    );

    // Stub engine: B_DONE high exactly dly cycles after the first B_GO cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 0;
            b_done <= 1'b0;
        end else if (b_rst || !b_go) begin
            cnt    <= 0;
            b_done <= 1'b0;
        end else begin
            cnt    <= cnt + 1;
            b_done <= (cnt == dly - 1);
        end
    end
    assign b_led = cnt[1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_pat(input int i, input int on, input int off, input int rep, input int sel);
        pat_on[i*T_W +: T_W]  = T_W'(on);
        pat_off[i*T_W +: T_W] = T_W'(off);
        pat_rep[i*R_W +: R_W] = R_W'(rep);
        pat_sel[i*2 +: 2]     = 2'(sel);
    endtask

    // Drives REQ for one cycle; returns at the negedge of cycle t+1.
    task automatic req_pulse(input logic [N_REQ-1:0] v);
        req = v;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_done(input string tag, input logic [N_REQ-1:0] exp);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done != '0) break;
        end
        chk(tag, 32'(done), 32'(exp));
    endtask

    initial begin
        int               cycles;
        logic [N_REQ-1:0] seen;
        logic             go_seen;
        logic [N_REQ-1:0] first_a, second_a;
        int               first_on, second_on;
        logic [2:0]       first_o, second_o;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy",   32'(busy),    0);
        chk("rst_go",     32'(b_go),    0);
        chk("rst_brst",   32'(b_rst),   0);
        chk("rst_active", 32'(active),  0);
        chk("rst_done",   32'(done),    0);
        chk("rst_ovr",    32'(led_ovr), 0);
        chk("rst_bon",    32'(b_on),    0);

        // Single request on requester 1
        dly = 20;
        set_pat(1, 10, 5, 3, 2);
        req_pulse(3'b010);
        chk("t1_busy",    32'(busy), 0);
        @(negedge clk);
        chk("t2_brst",    32'(b_rst),   1);
        chk("t2_go",      32'(b_go),    0);
        chk("t2_active",  32'(active),  32'b010);
        chk("t2_busy",    32'(busy),    1);
        chk("t2_on",      32'(b_on),    10);
        chk("t2_off",     32'(b_off),   5);
        chk("t2_rep",     32'(b_rep),   3);
        chk("t2_ovr",     32'(led_ovr), 32'b010);
        @(negedge clk);
        chk("t3_go",      32'(b_go),  1);
        chk("t3_brst",    32'(b_rst), 0);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (done != '0) break;
            chk("run_ledval", 32'(led_val), 32'({1'b0, b_led, 1'b0}));
        end
        chk("run_len",     cycles,        21);
        chk("fin_done",    32'(done),     32'b010);
        chk("fin_go",      32'(b_go),     0);
        chk("fin_active",  32'(active),   32'b010);
        chk("fin_ovr",     32'(led_ovr),  0);
        @(negedge clk);
        chk("idle_busy",   32'(busy),     0);
        chk("idle_done",   32'(done),     0);

        // Simultaneous requests 0 and 2
`ifdef BLINK_SCHED_RR_EN
        first_a = 3'b100; first_on = 7; first_o = 3'b100;
        second_a = 3'b001; second_on = 3; second_o = 3'b001;
`else
        first_a = 3'b001; first_on = 3; first_o = 3'b001;
        second_a = 3'b100; second_on = 7; second_o = 3'b100;
`endif
        dly = 3;
        set_pat(0, 3, 4, 1, 1);
        set_pat(2, 7, 1, 2, 3);
        req_pulse(3'b101);
        @(negedge clk);
        chk("arb1_active", 32'(active),  32'(first_a));
        chk("arb1_on",     32'(b_on),    first_on);
        chk("arb1_ovr",    32'(led_ovr), 32'(first_o));
        wait_done("arb1_done", first_a);
        @(negedge clk);
        chk("arb_gap_busy", 32'(busy), 0);
        @(negedge clk);
        chk("arb2_active", 32'(active),  32'(second_a));
        chk("arb2_on",     32'(b_on),    second_on);
        chk("arb2_ovr",    32'(led_ovr), 32'(second_o));
        wait_done("arb2_done", second_a);
        @(negedge clk);

        // REP = 0: LOAD then FINISH without B_GO
        set_pat(0, 4, 4, 0, 1);
        go_seen = 1'b0;
        req_pulse(3'b001);
        @(negedge clk);
        go_seen |= b_go;
        chk("r0_brst", 32'(b_rst),   1);
        chk("r0_ovr",  32'(led_ovr), 32'b001);
        @(negedge clk);
        go_seen |= b_go;
        chk("r0_done", 32'(done),    32'b001);
        chk("r0_ovr2", 32'(led_ovr), 0);
        @(negedge clk);
        go_seen |= b_go;
        chk("r0_busy",  32'(busy), 0);
        chk("r0_nogo",  32'(go_seen), 0);

        // CANCEL during RUN with requester 0 pending
        dly = 50;
        set_pat(1, 6, 6, 3, 1);
        req_pulse(3'b010);
        @(negedge clk);
        @(negedge clk);
        chk("can_go_pre", 32'(b_go), 1);
        set_pat(0, 2, 2, 1, 1);
        req_pulse(3'b001);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("can_go",     32'(b_go),   0);
        chk("can_busy",   32'(busy),   0);
        chk("can_active", 32'(active), 0);
        seen = done;
        repeat (5) begin
            @(negedge clk);
            seen |= done;
        end
        chk("can_nodone", 32'(seen), 0);
        chk("can_flush",  32'(busy), 0);

        // Asynchronous reset mid-RUN
        set_pat(2, 9, 9, 2, 3);
        req_pulse(3'b100);
        @(negedge clk);
        @(negedge clk);
        chk("ar_go_pre", 32'(b_go), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_go",     32'(b_go),    0);
        chk("ar_busy",   32'(busy),    0);
        chk("ar_active", 32'(active),  0);
        chk("ar_bon",    32'(b_on),    0);
        chk("ar_ovr",    32'(led_ovr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("ar_idle", 32'(busy), 0);

        // Re-request from the active requester during its own RUN
        dly = 6;
        set_pat(1, 10, 5, 1, 2);
        req_pulse(3'b010);
        @(negedge clk);
        @(negedge clk);
        set_pat(1, 2, 5, 1, 2);
        req_pulse(3'b010);
        wait_done("rr_done1", 3'b010);
        @(negedge clk);
        chk("rr_gap_busy", 32'(busy), 0);
        @(negedge clk);
        chk("rr_active2", 32'(active), 32'b010);
        chk("rr_on2",     32'(b_on),   2);
        chk("rr_brst2",   32'(b_rst),  1);
        wait_done("rr_done2", 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
